mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
Main control FSM for the multicycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives all datapath enables and muxes, and produces the 2-bit ALUOp consumed by the ALU decoder. It waits on a memory ready handshake and keeps a retired-instruction counter.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  instr[31:26] from the instruction register
mem_ready  in  1  memory completes current read/write this cycle
iord  out  1  0=PC addresses memory, 1=ALUOut
mem_write  out  1  memory write strobe
ir_write  out  1  instruction register load
pc_write  out  1  unconditional PC load
branch_eq  out  1  PC load if ALU zero
branch_ne  out  1  PC load if not ALU zero
pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target
alu_src_a  out  1  0=PC, 1=reg A
alu_src_b  out  2  00=reg B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
alu_op  out  2  00=add, 01=sub, 10=use funct (to ALU decoder)
reg_dst  out  1  0=rt, 1=rd
mem_to_reg  out  1  0=ALUOut, 1=memory data
reg_write  out  1  register file write
illegal_op  out  1  one-cycle pulse on an unsupported opcode
state_o  out  4  current state encoding (debug)
retired  out  CNT_W  count of completed instructions

Behaviour:
- Moore FSM with 4-bit state register. Encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12-15 are unreachable and go to FETCH.
- Outputs are combinational from state, plus mem_ready/opcode where noted. Any output not listed for a state is 0.
- Reset (rst_n low, asynchronous): state=FETCH, retired=0. ir_write, pc_write and mem_write are forced 0 while rst_n is low. Other outputs show FETCH values.
- FETCH: alu_src_b=01, alu_op=00, ir_write=pc_write=mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alu_src_b=11, alu_op=00. Next state by opcode:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 (R-type) -> EXECUTE
  - 000100 (beq) or 000101 (bne) -> BRANCH
  - 001000 (addi) -> ADDIEX
  - 000010 (j) -> JUMP
  - any other opcode -> FETCH, with illegal_op=1 for that cycle; retired is not incremented.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEMRD if opcode=lw, else MEMWR.
- MEMRD: iord=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: mem_to_reg=1, reg_write=1, reg_dst=0. Goes to FETCH.
- MEMWR: iord=1, mem_write=1. mem_write is held until mem_ready=1, then the FSM goes to FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Goes to ALUWB.
- ALUWB: reg_dst=1, reg_write=1. Goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01. branch_eq=1 if opcode=000100; branch_ne=1 if opcode=000101. Goes to FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0. Goes to FETCH.
- JUMP: pc_src=10, pc_write=1. Goes to FETCH.
- opcode is assumed stable from DECODE through the end of the instruction (the IR is not written outside FETCH).
- retired increments by 1 on each clock edge that moves the FSM from MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB or JUMP into FETCH. It wraps modulo 2^CNT_W.
- Per-instruction cycle counts with mem_ready always 1 (FETCH through the last state): lw=5, sw=4, R-type=4, addi=4, beq/bne=3, j=3.
- Reset asserted mid-instruction aborts it immediately: state goes to FETCH and no further write strobes are issued.

Test Plan:
- Release reset with mem_ready=1 and opcode=000000 -> states 0,1,6,7,0. alu_op=10 in EXECUTE, reg_dst=reg_write=1 in ALUWB, retired=1 after 4 cycles.
- lw (100011) with mem_ready low for 2 cycles in MEMRD -> state_o stays 3 for 3 cycles with iord=1. MEMWB then asserts mem_to_reg=reg_write=1. Total 7 cycles.
- sw (101011) with mem_ready low for 1 cycle in FETCH -> ir_write=pc_write=0 in the stall cycle and 1 in the next. In MEMWR, mem_write=1 for exactly 1 cycle. retired increments once.
- beq then bne -> BRANCH shows alu_op=01, pc_src=01. branch_eq=1/branch_ne=0 for beq, then the inverse for bne.
- opcode=111111 -> DECODE asserts illegal_op=1 for 1 cycle, next state is FETCH, retired unchanged.
- Assert rst_n=0 mid-MEMWR -> state_o=0 and mem_write=0 asynchronously before the next edge, retired=0. Preset retired to 2^CNT_W-1 via a completed-instruction sequence and confirm it wraps to 0.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch, decode,
// execute, memory and writeback, drives datapath enables/muxes and counts
// retired instructions.
module mips_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             iord,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic             branch_eq,
  output logic             branch_ne,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             illegal_op,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t state;
  state_t next_state;
  logic   retire_now;

  assign state_o = state;

  // Next-state selection; unused encodings fall back to FETCH
  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:   next_state = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW:   next_state = MEMADR;
          OP_RTYPE:       next_state = EXECUTE;
          OP_BEQ, OP_BNE: next_state = BRANCH;
          OP_ADDI:        next_state = ADDIEX;
          OP_J:           next_state = JUMP;
          default:        next_state = FETCH;
        endcase
      end
      MEMADR:  next_state = (opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   next_state = mem_ready ? MEMWB : MEMRD;
      MEMWB:   next_state = FETCH;
      MEMWR:   next_state = mem_ready ? FETCH : MEMWR;
      EXECUTE: next_state = ALUWB;
      ALUWB:   next_state = FETCH;
      BRANCH:  next_state = FETCH;
      ADDIEX:  next_state = ADDIWB;
      ADDIWB:  next_state = FETCH;
      JUMP:    next_state = FETCH;
      default: next_state = FETCH;
    endcase
  end

  // An instruction retires when its final state hands control back to FETCH
  always_comb begin
    retire_now = 1'b0;
    case (state)
      MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: retire_now = 1'b1;
      MEMWR:                              retire_now = mem_ready;
      default:                            retire_now = 1'b0;
    endcase
  end

  // State register and retired-instruction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH;
      retired <= '0;
    end else begin
      state <= next_state;
      if (retire_now) retired <= retired + CNT_W'(1);
    end
  end

  // Moore control outputs; write strobes are gated off while reset is held
  always_comb begin
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch_eq  = 1'b0;
    branch_ne  = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    illegal_op = 1'b0;
    case (state)
      FETCH: begin
        alu_src_b = 2'b01;
        ir_write  = mem_ready & rst_n;
        pc_write  = mem_ready & rst_n;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_J: illegal_op = 1'b0;
          default:                                               illegal_op = 1'b1;
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      MEMWR: begin
        iord      = 1'b1;
        mem_write = rst_n;
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        branch_eq = (opcode == OP_BEQ);
        branch_ne = (opcode == OP_BNE);
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      ADDIWB: reg_write = 1'b1;
      JUMP: begin
        pc_src   = 2'b10;
        pc_write = rst_n;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: instruction-level reference
// model builds the expected per-cycle state trace from opcode and stall counts.
module tb_mips_multicycle_ctrl;

  localparam int CNT_W = 4;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4,
                 S_MEMWR = 5, S_EXECUTE = 6, S_ALUWB = 7, S_BRANCH = 8, S_ADDIEX = 9,
                 S_ADDIWB = 10, S_JUMP = 11;

  localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100,
                         OP_BNE = 6'b000101, OP_ADDI = 6'b001000, OP_LW = 6'b100011,
                         OP_SW = 6'b101011;

  logic             clk;
  logic             rst_n;
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             iord, mem_write, ir_write, pc_write, branch_eq, branch_ne;
  logic [1:0]       pc_src;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic             reg_dst, mem_to_reg, reg_write, illegal_op;
  logic [3:0]       state_o;
  logic [CNT_W-1:0] retired;
  logic [17:0]      dut_ctrl;

  typedef struct {
    int   st;
    logic mr;
  } step_t;

  step_t seq[$];
  int    compared;
  int    mismatched;
  int    model_retired;

  mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .iord(iord), .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write),
    .branch_eq(branch_eq), .branch_ne(branch_ne), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .illegal_op(illegal_op), .state_o(state_o), .retired(retired)
  );

  assign dut_ctrl = {iord, mem_write, ir_write, pc_write, branch_eq, branch_ne, pc_src,
                     alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, illegal_op};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic is_legal(input logic [5:0] op);
    return (op == OP_R) || (op == OP_J) || (op == OP_BEQ) || (op == OP_BNE) ||
           (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
  endfunction

  // Expected control word for one cycle, straight from the output table
  function automatic logic [17:0] exp_ctrl(input int st, input logic mr, input logic [5:0] op);
    logic io, mw, irw, pcw, beq, bne, asa, rd, m2r, rw, ill;
    logic [1:0] ps, asb, aop;
    io = 0; mw = 0; irw = 0; pcw = 0; beq = 0; bne = 0; asa = 0;
    rd = 0; m2r = 0; rw = 0; ill = 0; ps = 2'b00; asb = 2'b00; aop = 2'b00;
    case (st)
      S_FETCH:   begin asb = 2'b01; irw = mr; pcw = mr; end
      S_DECODE:  begin asb = 2'b11; ill = !is_legal(op); end
      S_MEMADR:  begin asa = 1; asb = 2'b10; end
      S_MEMRD:   io = 1;
      S_MEMWB:   begin m2r = 1; rw = 1; end
      S_MEMWR:   begin io = 1; mw = 1; end
      S_EXECUTE: begin asa = 1; aop = 2'b10; end
      S_ALUWB:   begin rd = 1; rw = 1; end
      S_BRANCH:  begin asa = 1; aop = 2'b01; ps = 2'b01; beq = (op == OP_BEQ); bne = (op == OP_BNE); end
      S_ADDIEX:  begin asa = 1; asb = 2'b10; end
      S_ADDIWB:  rw = 1;
      S_JUMP:    begin ps = 2'b10; pcw = 1; end
      default: ;
    endcase
    return {io, mw, irw, pcw, beq, bne, ps, asa, asb, aop, rd, m2r, rw, ill};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Run one instruction from FETCH to its final state, checking every cycle.
  // Entered and left just after a rising edge.
  task automatic applyStimulus(input logic [5:0] op, input int fetch_stalls, input int mem_stalls);
    logic retires;
    seq.delete();
    for (int i = 0; i < fetch_stalls; i++) seq.push_back('{S_FETCH, 1'b0});
    seq.push_back('{S_FETCH, 1'b1});
    seq.push_back('{S_DECODE, 1'($urandom)});
    retires = 1'b1;
    case (op)
      OP_LW: begin
        seq.push_back('{S_MEMADR, 1'($urandom)});
        for (int i = 0; i < mem_stalls; i++) seq.push_back('{S_MEMRD, 1'b0});
        seq.push_back('{S_MEMRD, 1'b1});
        seq.push_back('{S_MEMWB, 1'($urandom)});
      end
      OP_SW: begin
        seq.push_back('{S_MEMADR, 1'($urandom)});
        for (int i = 0; i < mem_stalls; i++) seq.push_back('{S_MEMWR, 1'b0});
        seq.push_back('{S_MEMWR, 1'b1});
      end
      OP_R: begin
        seq.push_back('{S_EXECUTE, 1'($urandom)});
        seq.push_back('{S_ALUWB, 1'($urandom)});
      end
      OP_BEQ, OP_BNE: seq.push_back('{S_BRANCH, 1'($urandom)});
      OP_ADDI: begin
        seq.push_back('{S_ADDIEX, 1'($urandom)});
        seq.push_back('{S_ADDIWB, 1'($urandom)});
      end
      OP_J: seq.push_back('{S_JUMP, 1'($urandom)});
      default: retires = 1'b0;
    endcase
    opcode = op;
    foreach (seq[k]) begin
      mem_ready = seq[k].mr;
      @(negedge clk);
      checkOutput($sformatf("state op=%b step%0d", op, k), 32'(state_o), 32'(seq[k].st));
      checkOutput($sformatf("ctrl st=%0d mr=%b op=%b", seq[k].st, seq[k].mr, op),
                  32'(dut_ctrl), 32'(exp_ctrl(seq[k].st, seq[k].mr, op)));
      checkOutput("retired", 32'(retired), 32'(model_retired));
      @(posedge clk);
      #1;
    end
    if (retires) model_retired = (model_retired + 1) % (1 << CNT_W);
  endtask

  task automatic random_instr();
    logic [5:0] legal_ops[7] = '{OP_R, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW};
    logic [5:0] op;
    int idx;
    idx = $urandom_range(0, 7);
    if (idx < 7) op = legal_ops[idx];
    else begin
      op = 6'($urandom);
      while (is_legal(op)) op = 6'($urandom);
    end
    applyStimulus(op, $urandom_range(0, 2), $urandom_range(0, 2));
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    model_retired = 0;
    rst_n = 1'b0;
    opcode = OP_R;
    mem_ready = 1'b1;

    // Reset state: FETCH values with write strobes suppressed
    #12;
    checkOutput("reset state", 32'(state_o), 32'd0);
    checkOutput("reset ir_write", 32'(ir_write), 32'd0);
    checkOutput("reset pc_write", 32'(pc_write), 32'd0);
    checkOutput("reset alu_src_b", 32'(alu_src_b), 32'd1);
    checkOutput("reset retired", 32'(retired), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed instructions from the test plan
    applyStimulus(OP_R, 0, 0);
    applyStimulus(OP_LW, 0, 2);
    applyStimulus(OP_SW, 1, 0);
    applyStimulus(OP_BEQ, 0, 0);
    applyStimulus(OP_BNE, 0, 0);
    applyStimulus(6'b111111, 0, 0);
    applyStimulus(OP_ADDI, 1, 0);
    applyStimulus(OP_J, 0, 0);

    // Random instruction stream; long enough for the narrow counter to wrap
    for (int n = 0; n < 60; n++) random_instr();

    // Abort a store mid-MEMWR with an asynchronous reset
    opcode = OP_SW;
    mem_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;
    @(negedge clk);
    checkOutput("pre-abort state", 32'(state_o), 32'(S_MEMWR));
    checkOutput("pre-abort mem_write", 32'(mem_write), 32'd1);
    #2;
    mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort state", 32'(state_o), 32'd0);
    checkOutput("abort mem_write", 32'(mem_write), 32'd0);
    checkOutput("abort ir_write", 32'(ir_write), 32'd0);
    checkOutput("abort retired", 32'(retired), 32'd0);
    model_retired = 0;
    @(posedge clk);
    #1;
    checkOutput("held reset state", 32'(state_o), 32'd0);
    rst_n = 1'b1;

    for (int n = 0; n < 25; n++) random_instr();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
